// File: rtl/lc3_pkg.sv
// Shared LC-3 constants: state encoding, opcodes, mux select codes and the
// control-word layout driven by the sequencer into the datapath.
package lc3_pkg;

  localparam int unsigned STATE_W = 5;
  localparam int unsigned OP_W    = 4;

  // Sequencer states; values are visible on the debug state port
  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 5'd0,
    S_F0     = 5'd1,
    S_F1     = 5'd2,
    S_F2     = 5'd3,
    S_F3     = 5'd4,
    S_EX_ALU = 5'd5,
    S_EX_LEA = 5'd6,
    S_A0     = 5'd7,
    S_LD1    = 5'd8,
    S_LD2    = 5'd9,
    S_ST1    = 5'd10,
    S_ST2    = 5'd11,
    S_BR1    = 5'd12,
    S_EX_JMP = 5'd13,
    S_J0     = 5'd14,
    S_J1     = 5'd15,
    S_ILL    = 5'd16
  } state_t;

  // Supported opcodes (IR[15:12])
  localparam logic [OP_W-1:0] OP_BR  = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OP_W-1:0] OP_LD  = 4'b0010;
  localparam logic [OP_W-1:0] OP_ST  = 4'b0011;
  localparam logic [OP_W-1:0] OP_JSR = 4'b0100;
  localparam logic [OP_W-1:0] OP_AND = 4'b0101;
  localparam logic [OP_W-1:0] OP_NOT = 4'b1001;
  localparam logic [OP_W-1:0] OP_JMP = 4'b1100;
  localparam logic [OP_W-1:0] OP_LEA = 4'b1110;

  typedef enum logic [1:0] {
    PCMUX_INC   = 2'b00,
    PCMUX_BUS   = 2'b01,
    PCMUX_ADDER = 2'b10
  } pcmux_t;

  typedef enum logic {
    ADDR1_PC  = 1'b0,
    ADDR1_SR1 = 1'b1
  } addr1mux_t;

  typedef enum logic [1:0] {
    ADDR2_ZERO  = 2'b00,
    ADDR2_OFF6  = 2'b01,
    ADDR2_OFF9  = 2'b10,
    ADDR2_OFF11 = 2'b11
  } addr2mux_t;

  typedef enum logic [1:0] {
    DRMUX_IR11 = 2'b00,
    DRMUX_R6   = 2'b01,
    DRMUX_R7   = 2'b10
  } drmux_t;

  typedef enum logic [1:0] {
    SR1MUX_IR11 = 2'b00,
    SR1MUX_IR8  = 2'b01,
    SR1MUX_R6   = 2'b10
  } sr1mux_t;

  // Control word presented to the datapath every cycle
  typedef struct packed {
    logic      mem_en;
    logic      mem_we;
    logic      ld_mar;
    logic      ld_mdr;
    logic      ld_ir;
    logic      ld_pc;
    logic      ld_reg;
    logic      ld_cc;
    logic      gate_pc;
    logic      gate_mdr;
    logic      gate_alu;
    logic      gate_marmux;
    pcmux_t    pc_mux;
    addr1mux_t addr1_mux;
    addr2mux_t addr2_mux;
    drmux_t    dr_mux;
    sr1mux_t   sr1_mux;
    logic      illegal;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/lc3_ctrl_decode.sv
// Combinational state -> control-word decoder for the LC-3 sequencer.
// Ports:
//   i_state   - state whose control word is wanted
//   i_ir_jsr  - IR[11], selects JSR vs JSRR addressing in J1
//   o_ctrl    - packed ctrl_t control word
module lc3_ctrl_decode
  import lc3_pkg::*;
(
  input  logic [STATE_W-1:0] i_state,
  input  logic               i_ir_jsr,
  output logic [CTRL_W-1:0]  o_ctrl
);

  ctrl_t w_ctrl;

  // Anything not set for a state stays zero
  always_comb begin
    w_ctrl = '0;
    case (state_t'(i_state))
      S_F0: begin
        w_ctrl.gate_pc = 1'b1;
        w_ctrl.ld_mar  = 1'b1;
        w_ctrl.ld_pc   = 1'b1;
        w_ctrl.pc_mux  = PCMUX_INC;
      end
      S_F1, S_LD1: begin
        w_ctrl.mem_en = 1'b1;
        w_ctrl.ld_mdr = 1'b1;
      end
      S_F2: begin
        w_ctrl.gate_mdr = 1'b1;
        w_ctrl.ld_ir    = 1'b1;
      end
      S_EX_ALU: begin
        w_ctrl.sr1_mux  = SR1MUX_IR8;
        w_ctrl.dr_mux   = DRMUX_IR11;
        w_ctrl.gate_alu = 1'b1;
        w_ctrl.ld_reg   = 1'b1;
        w_ctrl.ld_cc    = 1'b1;
      end
      S_EX_LEA: begin
        w_ctrl.addr1_mux   = ADDR1_PC;
        w_ctrl.addr2_mux   = ADDR2_OFF9;
        w_ctrl.gate_marmux = 1'b1;
        w_ctrl.dr_mux      = DRMUX_IR11;
        w_ctrl.ld_reg      = 1'b1;
      end
      S_A0: begin
        w_ctrl.addr1_mux   = ADDR1_PC;
        w_ctrl.addr2_mux   = ADDR2_OFF9;
        w_ctrl.gate_marmux = 1'b1;
        w_ctrl.ld_mar      = 1'b1;
      end
      S_LD2: begin
        w_ctrl.gate_mdr = 1'b1;
        w_ctrl.dr_mux   = DRMUX_IR11;
        w_ctrl.ld_reg   = 1'b1;
        w_ctrl.ld_cc    = 1'b1;
      end
      S_ST1: begin
        // ALU passes SR (IR[11:9]) through to the bus for the MDR
        w_ctrl.sr1_mux  = SR1MUX_IR11;
        w_ctrl.gate_alu = 1'b1;
        w_ctrl.ld_mdr   = 1'b1;
      end
      S_ST2: begin
        w_ctrl.mem_en = 1'b1;
        w_ctrl.mem_we = 1'b1;
      end
      S_BR1: begin
        w_ctrl.addr1_mux = ADDR1_PC;
        w_ctrl.addr2_mux = ADDR2_OFF9;
        w_ctrl.pc_mux    = PCMUX_ADDER;
        w_ctrl.ld_pc     = 1'b1;
      end
      S_EX_JMP: begin
        w_ctrl.sr1_mux   = SR1MUX_IR8;
        w_ctrl.addr1_mux = ADDR1_SR1;
        w_ctrl.addr2_mux = ADDR2_ZERO;
        w_ctrl.pc_mux    = PCMUX_ADDER;
        w_ctrl.ld_pc     = 1'b1;
      end
      S_J0: begin
        // Link: PC -> R7
        w_ctrl.gate_pc = 1'b1;
        w_ctrl.dr_mux  = DRMUX_R7;
        w_ctrl.ld_reg  = 1'b1;
      end
      S_J1: begin
        w_ctrl.pc_mux = PCMUX_ADDER;
        w_ctrl.ld_pc  = 1'b1;
        if (i_ir_jsr) begin
          w_ctrl.addr1_mux = ADDR1_PC;
          w_ctrl.addr2_mux = ADDR2_OFF11;
        end else begin
          w_ctrl.addr1_mux = ADDR1_SR1;
          w_ctrl.sr1_mux   = SR1MUX_IR8;
          w_ctrl.addr2_mux = ADDR2_ZERO;
        end
      end
      S_ILL: w_ctrl.illegal = 1'b1;
      default: w_ctrl = '0;
    endcase
  end

  assign o_ctrl = w_ctrl;

endmodule

// File: rtl/lc3_ctrl_fsm.sv
// LC-3 multi-cycle control sequencer: fetch, decode, execute.
// Ports:
//   i_clk, i_rst        - clock, async active-high reset
//   i_run               - leaves IDLE when high (sampled only in IDLE)
//   i_ir_op, i_ir_jsr   - IR[15:12] and IR[11]
//   i_ben               - branch enable, valid in decode
//   i_mem_ready         - one-cycle memory completion pulse
//   o_mem_en/o_mem_we   - memory request / write qualifier
//   o_ld_*, o_gate_*    - datapath load enables and bus gates
//   o_*_mux             - datapath mux selects
//   o_illegal           - one-cycle unsupported-opcode pulse
//   o_state             - current state for debug
module lc3_ctrl_fsm
  import lc3_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_run,
  input  logic [3:0] i_ir_op,
  input  logic       i_ir_jsr,
  input  logic       i_ben,
  input  logic       i_mem_ready,
  output logic       o_mem_en,
  output logic       o_mem_we,
  output logic       o_ld_mar,
  output logic       o_ld_mdr,
  output logic       o_ld_ir,
  output logic       o_ld_pc,
  output logic       o_ld_reg,
  output logic       o_ld_cc,
  output logic       o_gate_pc,
  output logic       o_gate_mdr,
  output logic       o_gate_alu,
  output logic       o_gate_marmux,
  output logic [1:0] o_pc_mux,
  output logic       o_addr1_mux,
  output logic [1:0] o_addr2_mux,
  output logic [1:0] o_dr_mux,
  output logic [1:0] o_sr1_mux,
  output logic       o_illegal,
  output logic [4:0] o_state
);

  state_t              r_state;
  state_t              w_next_state;
  ctrl_t               r_ctrl;
  logic [CTRL_W-1:0]   w_ctrl_bits;

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (i_run) w_next_state = S_F0;
      S_F0:     w_next_state = S_F1;
      S_F1:     if (i_mem_ready) w_next_state = S_F2;
      S_F2:     w_next_state = S_F3;
      S_F3: begin
        case (i_ir_op)
          OP_ADD, OP_AND, OP_NOT: w_next_state = S_EX_ALU;
          OP_LEA:                 w_next_state = S_EX_LEA;
          OP_LD, OP_ST:           w_next_state = S_A0;
          OP_BR:                  w_next_state = i_ben ? S_BR1 : S_F0;
          OP_JMP:                 w_next_state = S_EX_JMP;
          OP_JSR:                 w_next_state = S_J0;
          default:                w_next_state = S_ILL;
        endcase
      end
      // A0 is shared by LD and ST; IR is stable so re-check the opcode
      S_A0:     w_next_state = (i_ir_op == OP_ST) ? S_ST1 : S_LD1;
      S_LD1:    if (i_mem_ready) w_next_state = S_LD2;
      S_ST1:    w_next_state = S_ST2;
      S_ST2:    if (i_mem_ready) w_next_state = S_F0;
      S_J0:     w_next_state = S_J1;
      S_EX_ALU, S_EX_LEA, S_LD2, S_BR1,
      S_EX_JMP, S_J1, S_ILL:
                w_next_state = S_F0;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Decode the upcoming state so outputs are registered alongside it
  lc3_ctrl_decode u_decode (
    .i_state  (w_next_state),
    .i_ir_jsr (i_ir_jsr),
    .o_ctrl   (w_ctrl_bits)
  );

  // State and control-word registers; reset clears both at once
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_next_state;
      r_ctrl  <= ctrl_t'(w_ctrl_bits);
    end
  end

  assign o_mem_en      = r_ctrl.mem_en;
  assign o_mem_we      = r_ctrl.mem_we;
  assign o_ld_mar      = r_ctrl.ld_mar;
  assign o_ld_mdr      = r_ctrl.ld_mdr;
  assign o_ld_ir       = r_ctrl.ld_ir;
  assign o_ld_pc       = r_ctrl.ld_pc;
  assign o_ld_reg      = r_ctrl.ld_reg;
  assign o_ld_cc       = r_ctrl.ld_cc;
  assign o_gate_pc     = r_ctrl.gate_pc;
  assign o_gate_mdr    = r_ctrl.gate_mdr;
  assign o_gate_alu    = r_ctrl.gate_alu;
  assign o_gate_marmux = r_ctrl.gate_marmux;
  assign o_pc_mux      = r_ctrl.pc_mux;
  assign o_addr1_mux   = r_ctrl.addr1_mux;
  assign o_addr2_mux   = r_ctrl.addr2_mux;
  assign o_dr_mux      = r_ctrl.dr_mux;
  assign o_sr1_mux     = r_ctrl.sr1_mux;
  assign o_illegal     = r_ctrl.illegal;
  assign o_state       = r_state;

endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// Bench for lc3_ctrl_fsm: reference model of the sequencer, expected
// state/control words queued as stimulus is driven, checked each cycle.
module tb_lc3_ctrl_fsm;
  import lc3_pkg::*;

  logic       clk = 1'b0;
  logic       rst, run, ir_jsr, ben, mem_ready;
  logic [3:0] ir_op;
  logic       o_mem_en, o_mem_we, o_ld_mar, o_ld_mdr, o_ld_ir, o_ld_pc;
  logic       o_ld_reg, o_ld_cc, o_gate_pc, o_gate_mdr, o_gate_alu, o_gate_marmux;
  logic [1:0] o_pc_mux, o_addr2_mux, o_dr_mux, o_sr1_mux;
  logic       o_addr1_mux, o_illegal;
  logic [4:0] o_state;

  always #5 clk = ~clk;

  lc3_ctrl_fsm dut (
    .i_clk(clk), .i_rst(rst), .i_run(run), .i_ir_op(ir_op), .i_ir_jsr(ir_jsr),
    .i_ben(ben), .i_mem_ready(mem_ready),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_ld_mar(o_ld_mar),
    .o_ld_mdr(o_ld_mdr), .o_ld_ir(o_ld_ir), .o_ld_pc(o_ld_pc),
    .o_ld_reg(o_ld_reg), .o_ld_cc(o_ld_cc), .o_gate_pc(o_gate_pc),
    .o_gate_mdr(o_gate_mdr), .o_gate_alu(o_gate_alu), .o_gate_marmux(o_gate_marmux),
    .o_pc_mux(o_pc_mux), .o_addr1_mux(o_addr1_mux), .o_addr2_mux(o_addr2_mux),
    .o_dr_mux(o_dr_mux), .o_sr1_mux(o_sr1_mux), .o_illegal(o_illegal),
    .o_state(o_state)
  );

  typedef struct packed {
    logic       mem_en, mem_we, ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pc_mux;
    logic       addr1_mux;
    logic [1:0] addr2_mux, dr_mux, sr1_mux;
    logic       illegal;
  } out_t;

  typedef struct {
    logic [4:0] st;
    out_t       o;
  } exp_t;

  typedef struct {
    logic [3:0] op;
    logic       jsr, ben, run;
    int         waits, cycles, ldreg, ldcc, ldpcx, ill;
  } vec_t;

  localparam int NV = 16;

  out_t       dut_out;
  exp_t       exp_q[$];
  vec_t       vecs[NV];
  logic [4:0] m_state;
  int         wait_cnt, cur_waits;
  int         checks = 0, failures = 0;
  int         n_ldreg, n_ldcc, n_ldpcx, n_ill, n_ld1_en, n_we_stray = 0;

  assign dut_out = {o_mem_en, o_mem_we, o_ld_mar, o_ld_mdr, o_ld_ir, o_ld_pc,
                    o_ld_reg, o_ld_cc, o_gate_pc, o_gate_mdr, o_gate_alu,
                    o_gate_marmux, o_pc_mux, o_addr1_mux, o_addr2_mux,
                    o_dr_mux, o_sr1_mux, o_illegal};

  function automatic logic is_wait(logic [4:0] s);
    return (s == S_F1) || (s == S_LD1) || (s == S_ST2);
  endfunction

  function automatic logic [4:0] model_next(logic [4:0] s);
    logic [4:0] n = s;
    case (s)
      S_IDLE:   if (run) n = S_F0;
      S_F0:     n = S_F1;
      S_F1:     if (mem_ready) n = S_F2;
      S_F2:     n = S_F3;
      S_F3: begin
        if (ir_op == 4'b0001 || ir_op == 4'b0101 || ir_op == 4'b1001) n = S_EX_ALU;
        else if (ir_op == 4'b1110) n = S_EX_LEA;
        else if (ir_op == 4'b0010 || ir_op == 4'b0011) n = S_A0;
        else if (ir_op == 4'b0000) n = ben ? S_BR1 : S_F0;
        else if (ir_op == 4'b1100) n = S_EX_JMP;
        else if (ir_op == 4'b0100) n = S_J0;
        else n = S_ILL;
      end
      S_A0:     n = (ir_op == 4'b0011) ? S_ST1 : S_LD1;
      S_LD1:    if (mem_ready) n = S_LD2;
      S_ST1:    n = S_ST2;
      S_ST2:    if (mem_ready) n = S_F0;
      S_J0:     n = S_J1;
      default:  n = S_F0;
    endcase
    return n;
  endfunction

  function automatic out_t exp_out(logic [4:0] s, logic jsr);
    out_t o = '0;
    case (s)
      S_F0:     begin o.gate_pc = 1; o.ld_mar = 1; o.ld_pc = 1; end
      S_F1:     begin o.mem_en = 1; o.ld_mdr = 1; end
      S_F2:     begin o.gate_mdr = 1; o.ld_ir = 1; end
      S_EX_ALU: begin o.sr1_mux = 2'b01; o.gate_alu = 1; o.ld_reg = 1; o.ld_cc = 1; end
      S_EX_LEA: begin o.addr2_mux = 2'b10; o.gate_marmux = 1; o.ld_reg = 1; end
      S_A0:     begin o.addr2_mux = 2'b10; o.gate_marmux = 1; o.ld_mar = 1; end
      S_LD1:    begin o.mem_en = 1; o.ld_mdr = 1; end
      S_LD2:    begin o.gate_mdr = 1; o.ld_reg = 1; o.ld_cc = 1; end
      S_ST1:    begin o.gate_alu = 1; o.ld_mdr = 1; end
      S_ST2:    begin o.mem_en = 1; o.mem_we = 1; end
      S_BR1:    begin o.addr2_mux = 2'b10; o.pc_mux = 2'b10; o.ld_pc = 1; end
      S_EX_JMP: begin o.sr1_mux = 2'b01; o.addr1_mux = 1; o.pc_mux = 2'b10; o.ld_pc = 1; end
      S_J0:     begin o.gate_pc = 1; o.dr_mux = 2'b10; o.ld_reg = 1; end
      S_J1: begin
        o.pc_mux = 2'b10; o.ld_pc = 1;
        if (jsr) o.addr2_mux = 2'b11;
        else begin o.addr1_mux = 1; o.sr1_mux = 2'b01; end
      end
      S_ILL:    o.illegal = 1;
      default:  o = '0;
    endcase
    return o;
  endfunction

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic check_pop(string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: scoreboard empty, state got %0d", tag, o_state);
      return;
    end
    e = exp_q.pop_front();
    checks++;
    if (o_state !== e.st) begin
      failures++;
      $display("FAIL %s state: got %0d expected %0d", tag, o_state, e.st);
    end
    checks++;
    if (dut_out !== e.o) begin
      failures++;
      $display("FAIL %s outputs (state %0d): got %h expected %h", tag, e.st, dut_out, e.o);
    end
    if (o_ld_reg) n_ldreg++;
    if (o_ld_cc) n_ldcc++;
    if (o_ld_pc && o_state != S_F0) n_ldpcx++;
    if (o_illegal) n_ill++;
    if (o_state == S_LD1 && o_mem_en && o_ld_mdr) n_ld1_en++;
    if (o_mem_we && o_state != S_ST2) n_we_stray++;
  endtask

  // Drive mem_ready for the coming edge, advance the model, queue expectation
  task automatic drive_push();
    logic [4:0] nx;
    if (is_wait(m_state)) begin
      mem_ready = (wait_cnt == cur_waits);
      wait_cnt++;
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
      wait_cnt = 0;
    end
    nx = model_next(m_state);
    if (nx != m_state) wait_cnt = 0;
    exp_q.push_back('{nx, exp_out(nx, ir_jsr)});
    m_state = nx;
  endtask

  task automatic cycle(string tag);
    @(negedge clk);
    check_pop(tag);
    drive_push();
  endtask

  task automatic run_vec(int idx, vec_t v);
    string tag;
    int n;
    tag = $sformatf("v%0d_op%b", idx, v.op);
    n_ldreg = 0; n_ldcc = 0; n_ldpcx = 0; n_ill = 0; n_ld1_en = 0;
    @(negedge clk);
    check_pop(tag);
    ir_op = v.op; ir_jsr = v.jsr; ben = v.ben; run = v.run; cur_waits = v.waits;
    drive_push();
    n = 1;
    while (m_state != S_F0 && n < 64) begin
      cycle(tag);
      n++;
    end
    if (n >= 64) begin
      checks++; failures++;
      $display("FAIL %s timeout: got %0d cycles without returning to F0", tag, n);
    end
    chk({tag, "_cycles"}, n, v.cycles);
    chk({tag, "_ld_reg_cnt"}, n_ldreg, v.ldreg);
    chk({tag, "_ld_cc_cnt"}, n_ldcc, v.ldcc);
    chk({tag, "_ld_pc_exec_cnt"}, n_ldpcx, v.ldpcx);
    chk({tag, "_illegal_cnt"}, n_ill, v.ill);
  endtask

  initial begin
    //            op       jsr   ben   run   w  cyc reg cc pcx ill
    vecs[0]  = '{4'b0001, 1'b0, 1'b0, 1'b1, 0,  5, 1, 1, 0, 0};
    vecs[1]  = '{4'b0101, 1'b0, 1'b1, 1'b1, 0,  5, 1, 1, 0, 0};
    vecs[2]  = '{4'b1001, 1'b0, 1'b0, 1'b1, 1,  6, 1, 1, 0, 0};
    vecs[3]  = '{4'b1110, 1'b0, 1'b0, 1'b1, 0,  5, 1, 0, 0, 0};
    vecs[4]  = '{4'b0010, 1'b0, 1'b0, 1'b1, 0,  7, 1, 1, 0, 0};
    vecs[5]  = '{4'b0010, 1'b0, 1'b0, 1'b1, 3, 13, 1, 1, 0, 0};
    vecs[6]  = '{4'b0011, 1'b0, 1'b0, 1'b0, 0,  7, 0, 0, 0, 0};
    vecs[7]  = '{4'b0011, 1'b0, 1'b0, 1'b1, 2, 11, 0, 0, 0, 0};
    vecs[8]  = '{4'b0000, 1'b0, 1'b1, 1'b1, 0,  5, 0, 0, 1, 0};
    vecs[9]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 0,  4, 0, 0, 0, 0};
    vecs[10] = '{4'b1100, 1'b0, 1'b0, 1'b1, 0,  5, 0, 0, 1, 0};
    vecs[11] = '{4'b0100, 1'b1, 1'b0, 1'b1, 0,  6, 1, 0, 1, 0};
    vecs[12] = '{4'b0100, 1'b0, 1'b0, 1'b1, 0,  6, 1, 0, 1, 0};
    vecs[13] = '{4'b1101, 1'b0, 1'b0, 1'b1, 0,  5, 0, 0, 0, 1};
    vecs[14] = '{4'b1000, 1'b0, 1'b0, 1'b1, 1,  6, 0, 0, 0, 1};
    vecs[15] = '{4'b1111, 1'b0, 1'b1, 1'b1, 0,  5, 0, 0, 0, 1};

    // Reset held with run high
    rst = 1'b1; run = 1'b1; ir_op = 4'b0001; ir_jsr = 1'b0; ben = 1'b0;
    mem_ready = 1'b0; cur_waits = 0; wait_cnt = 0;
    repeat (3) @(negedge clk);
    chk("reset_state", int'(o_state), int'(S_IDLE));
    chk("reset_outputs", int'(dut_out), 0);

    // Release: first F0 one cycle later
    rst = 1'b0;
    m_state = S_IDLE;
    drive_push();

    for (int i = 0; i < NV; i++) begin
      run_vec(i, vecs[i]);
      if (i == 5) chk("ld_wait3_mem_en_cycles", n_ld1_en, 4);
    end

    // Reset in the middle of an instruction-fetch wait
    @(negedge clk);
    check_pop("rst_f1_f0");
    ir_op = 4'b0001; cur_waits = 10;
    drive_push();
    @(negedge clk);
    check_pop("rst_f1_wait");
    mem_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_in_f1_mem_en", int'(o_mem_en), 0);
    chk("rst_in_f1_state", int'(o_state), int'(S_IDLE));
    exp_q.delete();

    // Release with run low: stay in IDLE
    @(negedge clk);
    rst = 1'b0; run = 1'b0; m_state = S_IDLE; wait_cnt = 0; cur_waits = 0;
    drive_push();
    repeat (3) cycle("idle_hold");
    @(negedge clk);
    check_pop("idle_exit");
    run = 1'b1;
    drive_push();
    run_vec(99, vecs[0]);

    chk("mem_we_outside_st2", n_we_stray, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
